// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator plant and its controller: engine/door
// commands, door-state reporting and cab FSM states.
package elevator_pkg;

  typedef enum logic [1:0] {
    ENG_STOP    = 2'b00,
    ENG_UP      = 2'b01,
    ENG_DOWN    = 2'b10,
    ENG_ILLEGAL = 2'b11
  } engine_cmd_e;

  typedef enum logic [1:0] {
    DOOR_HOLD    = 2'b00,
    DOOR_OPEN    = 2'b01,
    DOOR_CLOSE   = 2'b10,
    DOOR_ILLEGAL = 2'b11
  } door_cmd_e;

  typedef enum logic [1:0] {
    DS_CLOSED  = 2'b00,
    DS_OPENING = 2'b01,
    DS_OPEN    = 2'b10,
    DS_CLOSING = 2'b11
  } door_state_e;

  typedef enum logic [1:0] {
    CAB_IDLE      = 2'b00,
    CAB_MOVE_UP   = 2'b01,
    CAB_MOVE_DOWN = 2'b10,
    CAB_FAULT     = 2'b11
  } cab_state_e;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_door.sv
// Door plant: stroke timer and CLOSED/OPENING/OPEN/CLOSING sequencing.
// Frozen whenever the shaft is faulted or faulting this edge.
module elevator_door
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] door_cmd,
  input  logic       open_ok,
  input  logic       freeze,
  output logic [1:0] door_state
);

  localparam int TIMER_W = width_of(DOOR_TICKS);
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(DOOR_TICKS - 1);

  door_state_e            state_reg, state_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  door_cmd_e              cmd;

  assign cmd = door_cmd_e'(door_cmd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= DS_CLOSED;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    if (!freeze) begin
      case (state_reg)
        DS_CLOSED: begin
          if (cmd == DOOR_OPEN && open_ok) begin
            state_next = DS_OPENING;
            timer_next = '0;
          end
        end
        DS_OPENING: begin
          // Close requests are ignored until the stroke completes.
          if (timer_reg == LAST_TICK) begin
            state_next = DS_OPEN;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        DS_OPEN: begin
          if (cmd == DOOR_CLOSE) begin
            state_next = DS_CLOSING;
            timer_next = '0;
          end
        end
        DS_CLOSING: begin
          if (cmd == DOOR_OPEN) begin
            state_next = DS_OPENING;
            timer_next = '0;
          end else if (timer_reg == LAST_TICK) begin
            state_next = DS_CLOSED;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: begin
          state_next = DS_CLOSED;
          timer_next = '0;
        end
      endcase
    end
  end

  assign door_state = state_reg;

endmodule

// File: rtl/elevator_shaft.sv
// Cab/door plant model driven by the elevator controller: position counter,
// floor sensors, sticky plant-violation detection and the door sub-plant.
module elevator_shaft
  import elevator_pkg::*;
#(
  parameter int FLOORS          = 8,
  parameter int TICKS_PER_FLOOR = 4,
  parameter int DOOR_TICKS      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                engine,
  input  logic [1:0]                door,
  output logic                      sensor_up,
  output logic                      sensor_down,
  output logic [$clog2(FLOORS)-1:0] cab_floor,
  output logic                      at_floor,
  output logic [1:0]                door_state,
  output logic                      fault
);

  localparam int FLOOR_W   = $clog2(FLOORS);
  localparam int POS_MAX_I = (FLOORS - 1) * TICKS_PER_FLOOR;
  localparam int POS_W     = width_of(POS_MAX_I + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(POS_MAX_I);
  localparam logic [POS_W-1:0] TPF     = POS_W'(TICKS_PER_FLOOR);

  cab_state_e          cab_state_reg, cab_state_next;
  logic [POS_W-1:0]    pos_reg, pos_next;
  logic                sensor_up_reg, sensor_up_next;
  logic                sensor_down_reg, sensor_down_next;
  logic [FLOOR_W-1:0]  last_floor_reg, last_floor_next;
  logic [FLOOR_W-1:0]  arrive_floor;

  engine_cmd_e         eng;
  door_cmd_e           dcmd;
  door_state_e         door_state_w;
  logic [1:0]          door_bits;
  logic                at_floor_w;
  logic                violation;
  logic                door_freeze;
  logic                open_ok;

  assign eng          = engine_cmd_e'(engine);
  assign dcmd         = door_cmd_e'(door);
  assign door_state_w = door_state_e'(door_bits);
  assign at_floor_w   = ((pos_reg % TPF) == '0);

  assign violation = (eng == ENG_ILLEGAL)
                  || (dcmd == DOOR_ILLEGAL)
                  || ((eng != ENG_STOP) && (door_state_w != DS_CLOSED))
                  || ((dcmd == DOOR_OPEN) && (!at_floor_w || (eng != ENG_STOP)))
                  || ((eng == ENG_UP) && (pos_reg == POS_MAX))
                  || ((eng == ENG_DOWN) && (pos_reg == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cab_state_reg   <= CAB_IDLE;
      pos_reg         <= '0;
      sensor_up_reg   <= 1'b0;
      sensor_down_reg <= 1'b0;
      last_floor_reg  <= '0;
    end else begin
      cab_state_reg   <= cab_state_next;
      pos_reg         <= pos_next;
      sensor_up_reg   <= sensor_up_next;
      sensor_down_reg <= sensor_down_next;
      last_floor_reg  <= last_floor_next;
    end
  end

  always_comb begin
    cab_state_next   = cab_state_reg;
    pos_next         = pos_reg;
    sensor_up_next   = 1'b0;
    sensor_down_next = 1'b0;
    last_floor_next  = last_floor_reg;
    arrive_floor     = last_floor_reg;
    if (cab_state_reg != CAB_FAULT) begin
      if (violation) begin
        cab_state_next = CAB_FAULT;
      end else begin
        case (eng)
          ENG_UP: begin
            cab_state_next = CAB_MOVE_UP;
            pos_next       = pos_reg + 1'b1;
          end
          ENG_DOWN: begin
            cab_state_next = CAB_MOVE_DOWN;
            pos_next       = pos_reg - 1'b1;
          end
          default: cab_state_next = CAB_IDLE;
        endcase
        // Returning to the floor just left (mid-floor reversal) is not an arrival.
        if ((cab_state_next != CAB_IDLE) && ((pos_next % TPF) == '0)) begin
          arrive_floor    = FLOOR_W'(pos_next / TPF);
          last_floor_next = arrive_floor;
          if (arrive_floor != last_floor_reg) begin
            sensor_up_next   = (cab_state_next == CAB_MOVE_UP);
            sensor_down_next = (cab_state_next == CAB_MOVE_DOWN);
          end
        end
      end
    end
  end

  assign open_ok     = at_floor_w && (eng == ENG_STOP);
  assign door_freeze = (cab_state_reg == CAB_FAULT) || violation;

  elevator_door #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk       (clk),
    .reset     (reset),
    .door_cmd  (door),
    .open_ok   (open_ok),
    .freeze    (door_freeze),
    .door_state(door_bits)
  );

  assign sensor_up   = sensor_up_reg;
  assign sensor_down = sensor_down_reg;
  assign cab_floor   = FLOOR_W'(pos_reg / TPF);
  assign at_floor    = at_floor_w;
  assign door_state  = door_bits;
  assign fault       = (cab_state_reg == CAB_FAULT);

endmodule

// File: tb/tb_elevator_shaft.sv
// Scoreboard bench for elevator_shaft: directed scenarios plus randomized
// commands, checked cycle by cycle against an integer reference model.
module tb_elevator_shaft;

  localparam int FLOORS  = 8;
  localparam int TPF     = 4;
  localparam int DT      = 3;
  localparam int POS_MAX = (FLOORS - 1) * TPF;
  localparam int CLOSED  = 0;
  localparam int OPENING = 1;
  localparam int OPEN    = 2;
  localparam int CLOSING = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] engine = 2'b00;
  logic [1:0] door = 2'b00;
  logic       sensor_up, sensor_down, at_floor, fault;
  logic [2:0] cab_floor;
  logic [1:0] door_state;

  elevator_shaft #(
    .FLOORS(FLOORS), .TICKS_PER_FLOOR(TPF), .DOOR_TICKS(DT)
  ) dut (
    .clk(clk), .reset(reset), .engine(engine), .door(door),
    .sensor_up(sensor_up), .sensor_down(sensor_down), .cab_floor(cab_floor),
    .at_floor(at_floor), .door_state(door_state), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int su; int sd; int floor; int at; int ds; int flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain integers following the plant rules.
  int m_pos, m_door, m_left, m_last, m_fault, m_su, m_sd;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.su = m_su; e.sd = m_sd; e.floor = m_pos / TPF;
    e.at = (m_pos % TPF == 0) ? 1 : 0; e.ds = m_door; e.flt = m_fault;
    return e;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_door = CLOSED; m_left = 0; m_last = 0;
    m_fault = 0; m_su = 0; m_sd = 0;
  endfunction

  function automatic void model_step(input int eng, input int dcmd);
    int np;
    bit viol;
    m_su = 0; m_sd = 0;
    if (m_fault != 0) return;
    viol = (eng == 3) || (dcmd == 3) || (eng != 0 && m_door != CLOSED)
        || (dcmd == 1 && (m_pos % TPF != 0 || eng != 0))
        || (eng == 1 && m_pos == POS_MAX) || (eng == 2 && m_pos == 0);
    if (viol) begin
      m_fault = 1;
      return;
    end
    np = m_pos;
    if (eng == 1) np = m_pos + 1;
    if (eng == 2) np = m_pos - 1;
    if (np != m_pos && np % TPF == 0) begin
      if (np / TPF != m_last) begin
        m_su = (eng == 1) ? 1 : 0;
        m_sd = (eng == 2) ? 1 : 0;
      end
      m_last = np / TPF;
    end
    m_pos = np;
    case (m_door)
      CLOSED:  if (dcmd == 1) begin m_door = OPENING; m_left = DT; end
      OPENING: if (m_left == 1) m_door = OPEN; else m_left--;
      OPEN:    if (dcmd == 2) begin m_door = CLOSING; m_left = DT; end
      default: begin
        if (dcmd == 1) begin m_door = OPENING; m_left = DT; end
        else if (m_left == 1) m_door = CLOSED;
        else m_left--;
      end
    endcase
  endfunction

  // Apply one cycle of commands at a falling edge; expectation for the next rise.
  task automatic step(input bit rst, input int eng, input int dcmd);
    reset  = rst;
    engine = eng[1:0];
    door   = dcmd[1:0];
    if (rst) begin
      #1;
      check("async_rst_floor", cab_floor, 0);
      check("async_rst_door", door_state, CLOSED);
      check("async_rst_fault", fault, 0);
      check("async_rst_sensors", {sensor_up, sensor_down}, 0);
      model_reset();
    end else begin
      model_step(eng, dcmd);
    end
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic steps(input int n, input int eng, input int dcmd);
    for (int k = 0; k < n; k++) step(1'b0, eng, dcmd);
  endtask

  // Monitor: one expectation per rising edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sensor_up", sensor_up, e.su);
        check("sensor_down", sensor_down, e.sd);
        check("cab_floor", cab_floor, e.floor);
        check("at_floor", at_floor, e.at);
        check("door_state", door_state, e.ds);
        check("fault", fault, e.flt);
        $display("cyc t=%0t floor=%0d at=%0d su=%0d sd=%0d door=%0d fault=%0d",
                 $time, cab_floor, at_floor, sensor_up, sensor_down, door_state, fault);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b1, 0, 0);

    steps(28, 1, 0);
    check("climb_floor", cab_floor, 7);
    check("climb_at_floor", at_floor, 1);
    check("climb_fault", fault, 0);

    steps(12, 2, 0);
    check("descend_floor", cab_floor, 4);
    check("descend_at_floor", at_floor, 1);

    step(1'b0, 0, 1);
    steps(3, 0, 0);
    check("door_opened", door_state, OPEN);
    step(1'b0, 0, 2);
    steps(3, 0, 0);
    check("door_closed", door_state, CLOSED);

    step(1'b1, 0, 0);
    steps(2, 1, 0);
    steps(2, 2, 0);
    check("reverse_floor", cab_floor, 0);
    check("reverse_at_floor", at_floor, 1);
    step(1'b0, 2, 0);
    check("bottom_fault", fault, 1);
    check("bottom_at_floor", at_floor, 1);

    step(1'b1, 0, 0);
    steps(8, 1, 0);
    step(1'b0, 0, 1);
    steps(3, 0, 0);
    step(1'b0, 1, 0);
    check("open_move_fault", fault, 1);
    check("open_move_floor", cab_floor, 2);
    steps(3, 1, 0);
    check("fault_sticky", fault, 1);
    step(1'b1, 0, 0);
    step(1'b0, 0, 0);
    check("post_reset_fault", fault, 0);

    steps(12, 1, 0);
    step(1'b0, 0, 1);
    steps(3, 0, 0);
    step(1'b0, 0, 2);
    step(1'b0, 0, 0);
    step(1'b0, 0, 1);
    steps(2, 0, 0);
    check("reopen_opening", door_state, OPENING);
    step(1'b0, 0, 0);
    check("reopen_open", door_state, OPEN);
    check("reopen_fault", fault, 0);
    step(1'b0, 0, 2);
    steps(3, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      int r, eng, dc;
      r = $urandom_range(0, 99);
      if (m_fault != 0) begin
        if (r < 25) step(1'b1, 0, 0);
        else step(1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
        continue;
      end
      if (r == 99) begin step(1'b1, $urandom_range(0, 2), 0); continue; end
      if (r == 98) begin step(1'b0, 3, 0); continue; end
      if (r == 97) begin step(1'b0, 0, 3); continue; end
      if (m_door != CLOSED) begin
        eng = (r < 3) ? 1 : 0;
      end else if (m_pos % TPF == 0 && r < 40) begin
        eng = 0;
      end else begin
        eng = $urandom_range(1, 2);
        if (eng == 1 && m_pos == POS_MAX && r >= 5) eng = 2;
        if (eng == 2 && m_pos == 0 && r >= 5) eng = 1;
      end
      if (m_pos % TPF == 0 && eng == 0) dc = $urandom_range(0, 2);
      else dc = (r == 50) ? 1 : 0;
      step(1'b0, eng, dc);
    end

    step(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_shaft.md
ELEVATOR_SHAFT -- requirements
Module: elevator_shaft

Interface
REQ-001 Parameter FLOORS, 8, number of floors (cab_floor width = 3 bits at default).
REQ-002 Parameter TICKS_PER_FLOOR, 4, clock cycles of travel between adjacent floors.
REQ-003 Parameter DOOR_TICKS, 3, clock cycles for a full door open or close stroke.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port engine  input  2  motor command from controller: 00 stop, 01 up, 10 down, 11 illegal.
REQ-007 Port door  input  2  door command from controller: 00 hold, 01 open, 10 close, 11 illegal.
REQ-008 Port sensor_up  output  1  one-cycle pulse: cab reached a floor while moving up.
REQ-009 Port sensor_down  output  1  one-cycle pulse: cab reached a floor while moving down.
REQ-010 Port cab_floor  output  3  floor index = pos / TICKS_PER_FLOOR (truncating).
REQ-011 Port at_floor  output  1  high when pos is an exact multiple of TICKS_PER_FLOOR.
REQ-012 Port door_state  output  2  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING.
REQ-013 Port fault  output  1  sticky plant-violation flag.

Function
REQ-014 Block SHALL model the cab/door plant driven by the elevator controller, holding position counter pos in 0..(FLOORS-1)*TICKS_PER_FLOOR.
REQ-015 Cab FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, FAULT; state follows engine each cycle (00->IDLE, 01->MOVE_UP, 10->MOVE_DOWN).
REQ-016 In MOVE_UP pos SHALL increment by 1 per cycle; in MOVE_DOWN decrement by 1; IDLE/FAULT hold pos.
REQ-017 Engine command SHALL take effect on the edge it is sampled (zero-cycle latency to pos).
REQ-018 sensor_up/sensor_down SHALL be registered and high exactly in the cycle pos first becomes a floor multiple by up/down motion; never both high.
REQ-019 Direction reversal mid-floor SHALL reverse pos immediately; no sensor pulse until next multiple.
REQ-020 Door FSM: CLOSED+open (only when at_floor and engine=00) -> OPENING; OPENING -> OPEN after DOOR_TICKS cycles; OPEN+close -> CLOSING; CLOSING -> CLOSED after DOOR_TICKS cycles.
REQ-021 Open command during CLOSING SHALL restart OPENING with full DOOR_TICKS; close during OPENING SHALL be ignored; hold SHALL change nothing.
REQ-022 fault SHALL set (and cab FSM enter FAULT) on: engine=11; door=11; engine!=00 while door_state!=CLOSED; open while not at_floor or engine!=00; up at top floor multiple; down at pos=0.
REQ-023 In FAULT pos, door_state frozen, sensors low, until reset; fault is never cleared by commands.
REQ-024 Simultaneous violation and valid motion SHALL resolve as fault (no pos change that edge).

Reset
REQ-025 Reset SHALL force pos=0, cab_floor=0, at_floor=1, door_state=CLOSED, sensor_up=0, sensor_down=0, fault=0, cab FSM=IDLE, door timer=0.
REQ-026 Reset asserted mid-travel or mid-stroke SHALL abort immediately and asynchronously; first post-reset edge samples commands normally.

Structure
REQ-027 Engine and door command encodings, door_state encodings and cab state encodings SHALL live in shared package elevator_pkg, reused by the controller.
REQ-028 Door timer/FSM SHALL be sub-module elevator_door; position/fault logic stays in elevator_shaft.

Verification
REQ-029 Reset, engine=01 for 28 cycles -> sensor_up pulses at cycles 4,8,...,28, cab_floor=7, at_floor=1, fault=0.
REQ-030 From floor 7, engine=10 for 12 cycles -> three sensor_down pulses, cab_floor=4, at_floor=1.
REQ-031 At floor 4, engine=00, door=01 one cycle -> OPENING 3 cycles then OPEN; door=10 -> CLOSING 3 cycles then CLOSED.
REQ-032 Engine=01 for 2 cycles from floor 0 then 10 for 2 cycles -> pos=0, no sensor pulse; then engine=10 once more -> fault=1, pos stays 0.
REQ-033 Door OPEN at floor 2, engine=01 -> fault=1, pos unchanged, persists until reset; reset -> all REQ-025 values.
REQ-034 CLOSING at floor 3, door=01 in second closing cycle -> OPENING restarts, OPEN after 3 further cycles, fault=0.
